// File: rtl/conv_layer_sequencer.sv
// Sequences one convolution layer through a shared 3x3 multi-channel filter datapath:
// issues window/weight fetches, accumulates group partials, then clips, applies leaky ReLU and streams pixels.
module conv_layer_sequencer #(
  parameter int WIDTH  = 10,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int OUT_CH = 8,
  parameter int GROUPS = 4,
  parameter int ACC_X  = 4,
  localparam int RW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1,
  localparam int CW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1,
  localparam int OW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cfg_clip,
  input  logic                    cfg_relu,
  input  logic [7:0]              cfg_relu_c,
  output logic                    busy,
  output logic                    done,
  output logic                    fetch_valid,
  input  logic                    fetch_ready,
  output logic [RW-1:0]           fetch_row,
  output logic [CW-1:0]           fetch_col,
  output logic [OW-1:0]           fetch_och,
  output logic [GW-1:0]           fetch_grp,
  input  logic                    dp_valid,
  input  logic signed [WIDTH-1:0] dp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [RW-1:0]           out_row,
  output logic [CW-1:0]           out_col,
  output logic [OW-1:0]           out_och,
  output logic                    err
);
  localparam int AW    = WIDTH + ACC_X;
  localparam int PW    = WIDTH + 9;
  localparam int MAX_I = 2**(WIDTH-1) - 1;
  localparam int MIN_I = -(2**(WIDTH-1));
  localparam logic signed [AW-1:0] MAX_V = MAX_I[AW-1:0];
  localparam logic signed [AW-1:0] MIN_V = MIN_I[AW-1:0];
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [OW-1:0] OCH_MAX = OW'(OUT_CH - 1);
  localparam logic [GW-1:0] GRP_MAX = GW'(GROUPS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;
  state_t state_reg;

  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [OW-1:0] och_reg;
  logic [GW-1:0] grp_reg;
  logic signed [AW-1:0] acc_reg;
  logic clip_reg, relu_reg;
  logic [7:0] relu_c_reg;

  logic signed [AW-1:0]    sum_next;
  logic signed [WIDTH-1:0] clipped_next, result_next;
  logic signed [8:0]       slope;
  logic signed [PW-1:0]    prod, prod_shift;
  logic grp_last, pix_last;

  assign fetch_row = row_reg;
  assign fetch_col = col_reg;
  assign fetch_och = och_reg;
  assign fetch_grp = grp_reg;
  assign grp_last  = (grp_reg == GRP_MAX);
  assign pix_last  = (row_reg == ROW_MAX) && (col_reg == COL_MAX) && (och_reg == OCH_MAX);

  // Post-processing works on the sum including the partial arriving this cycle,
  // so the finished pixel can be registered on the same edge that enters EMIT.
  always_comb begin
    sum_next = ((grp_reg == '0) ? '0 : acc_reg) + {{ACC_X{dp_data[WIDTH-1]}}, dp_data};
    if (clip_reg && (sum_next > MAX_V))
      clipped_next = MAX_V[WIDTH-1:0];
    else if (clip_reg && (sum_next < MIN_V))
      clipped_next = MIN_V[WIDTH-1:0];
    else
      clipped_next = sum_next[WIDTH-1:0];
    slope       = {1'b0, relu_c_reg};
    prod        = PW'(clipped_next) * PW'(slope);
    prod_shift  = prod >>> 8;
    result_next = (relu_reg && clipped_next[WIDTH-1]) ? prod_shift[WIDTH-1:0] : clipped_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      row_reg     <= '0;
      col_reg     <= '0;
      och_reg     <= '0;
      grp_reg     <= '0;
      acc_reg     <= '0;
      clip_reg    <= 1'b0;
      relu_reg    <= 1'b0;
      relu_c_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fetch_valid <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_och     <= '0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dp_valid && (state_reg != WAIT))
        err <= 1'b1;
      case (state_reg)
        IDLE: if (start) begin
          clip_reg    <= cfg_clip;
          relu_reg    <= cfg_relu;
          relu_c_reg  <= cfg_relu_c;
          row_reg     <= '0;
          col_reg     <= '0;
          och_reg     <= '0;
          grp_reg     <= '0;
          acc_reg     <= '0;
          err         <= 1'b0;
          busy        <= 1'b1;
          fetch_valid <= 1'b1;
          state_reg   <= ISSUE;
        end
        ISSUE: if (fetch_ready) begin
          fetch_valid <= 1'b0;
          state_reg   <= WAIT;
        end
        WAIT: if (dp_valid) begin
          acc_reg <= sum_next;
          if (!grp_last) begin
            grp_reg     <= grp_reg + GW'(1);
            fetch_valid <= 1'b1;
            state_reg   <= ISSUE;
          end else begin
            out_valid <= 1'b1;
            out_data  <= result_next;
            out_row   <= row_reg;
            out_col   <= col_reg;
            out_och   <= och_reg;
            state_reg <= EMIT;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          grp_reg   <= '0;
          if (pix_last) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
            // och is innermost, then col, then row
            if (och_reg == OCH_MAX) begin
              och_reg <= '0;
              if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= row_reg + RW'(1);
              end else begin
                col_reg <= col_reg + CW'(1);
              end
            end else begin
              och_reg <= och_reg + OW'(1);
            end
            fetch_valid <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench: 2x2 image, 2 output channels, 3 groups; a negedge responder models
// the fetch buffers, datapath and output consumer.
module tb_conv_layer_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, cfg_clip = 1'b0, cfg_relu = 1'b0;
  logic [7:0] cfg_relu_c = '0;
  logic busy, done, fetch_valid, err, out_valid;
  logic fetch_ready = 1'b0, out_ready = 1'b0, dp_valid = 1'b0;
  logic [0:0] fetch_row, fetch_col, fetch_och, out_row, out_col, out_och;
  logic [1:0] fetch_grp;
  logic signed [9:0] dp_data = '0;
  logic signed [9:0] out_data;

  conv_layer_sequencer #(.WIDTH(10), .IMG_W(2), .IMG_H(2), .OUT_CH(2), .GROUPS(3), .ACC_X(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_clip(cfg_clip), .cfg_relu(cfg_relu),
    .cfg_relu_c(cfg_relu_c), .busy(busy), .done(done), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_row(fetch_row), .fetch_col(fetch_col),
    .fetch_och(fetch_och), .fetch_grp(fetch_grp), .dp_valid(dp_valid), .dp_data(dp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_och(out_och), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int col; int och; int data; int cyc;} pix_t;
  pix_t pixq[$];
  int part [0:3];
  int n_checks = 0, n_fail = 0;
  int cycle = 0, done_cnt = 0, done_cyc = 0, unstable = 0;
  int fstall_cnt = 0, fstall_target = 0, ostall_cnt = 0, ostall_target = 0;
  int inj_cnt = 0, inj_target = 0;
  logic pending = 1'b0;
  logic [1:0] pend_grp = '0;
  logic prev_fstall = 1'b0, prev_ostall = 1'b0;
  logic [4:0] prev_fc = '0;
  logic [12:0] prev_oc = '0;

  // Responder: drives DUT inputs for the coming edge, then records what that edge will accept.
  always @(negedge clk) begin
    cycle++;
    if (done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (prev_fstall && (!fetch_valid || {fetch_row, fetch_col, fetch_och, fetch_grp} != prev_fc))
      unstable++;
    if (prev_ostall && (!out_valid || {out_row, out_col, out_och, out_data} != prev_oc))
      unstable++;
    dp_valid = pending;
    dp_data  = 10'(part[pend_grp]);
    if (inj_cnt < inj_target && fetch_valid) begin
      dp_valid = 1'b1;
      dp_data  = 10'sd200;
      inj_cnt++;
    end
    fetch_ready = !(fstall_cnt < fstall_target && fetch_valid);
    if (!fetch_ready) fstall_cnt++;
    out_ready = !(ostall_cnt < ostall_target && out_valid);
    if (!out_ready) ostall_cnt++;
    pending  = fetch_valid && fetch_ready;
    pend_grp = fetch_grp;
    if (out_valid && out_ready)
      pixq.push_back('{int'(out_row), int'(out_col), int'(out_och), int'(out_data), cycle});
    prev_fstall = fetch_valid && !fetch_ready;
    prev_fc     = {fetch_row, fetch_col, fetch_och, fetch_grp};
    prev_ostall = out_valid && !out_ready;
    prev_oc     = {out_row, out_col, out_och, out_data};
  end

  task automatic run_layer(input string name, input bit clip, input bit relu, input logic [7:0] c,
                           input int p0, input int p1, input int p2, input int expv,
                           input bit chk_timing, input bit busy_start);
    int base, dbase, got_n;
    base  = pixq.size();
    dbase = done_cnt;
    @(negedge clk);
    part[0] = p0; part[1] = p1; part[2] = p2; part[3] = 0;
    cfg_clip = clip; cfg_relu = relu; cfg_relu_c = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_clip = !clip; cfg_relu = !relu; cfg_relu_c = ~c;
    if (busy_start) begin
      repeat (10) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_at_restart: got %b expected 1", name, busy); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 1000 && done_cnt == dbase; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - dbase != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - dbase);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done: got %b expected 0", name, busy); end
    got_n = pixq.size() - base;
    n_checks++;
    if (got_n != 8) begin n_fail++; $display("FAIL %s pixel_count: got %0d expected 8", name, got_n); end
    for (int k = 0; k < 8 && k < got_n; k++) begin
      pix_t p;
      p = pixq[base + k];
      n_checks++;
      if (p.row * 4 + p.col * 2 + p.och != k || p.data != expv) begin
        n_fail++;
        $display("FAIL %s pix%0d: got (r%0d c%0d o%0d) %0d expected (r%0d c%0d o%0d) %0d",
                 name, k, p.row, p.col, p.och, p.data, k / 4, (k / 2) % 2, k % 2, expv);
      end
      if (chk_timing && k > 0) begin
        n_checks++;
        if (p.cyc - pixq[base + k - 1].cyc != 7) begin
          n_fail++; $display("FAIL %s pix%0d_interval: got %0d expected 7", name, k, p.cyc - pixq[base + k - 1].cyc);
        end
      end
    end
    if (chk_timing && got_n == 8) begin
      n_checks++;
      if (done_cyc - pixq[base + 7].cyc != 1) begin
        n_fail++; $display("FAIL %s done_latency: got %0d expected 1", name, done_cyc - pixq[base + 7].cyc);
      end
    end
    $display("layer %s: %0d pixels, expected value %0d", name, got_n, expv);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, fetch_valid, out_valid, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, fetch_valid, out_valid, err});
    end
    n_checks++;
    if ({out_data, out_row, out_col, out_och, fetch_row, fetch_col, fetch_och, fetch_grp} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data);
    end
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_basic();
    run_layer("basic", 1'b0, 1'b0, 8'd0, 100, 100, 100, 300, 1'b1, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_clip();
    run_layer("clip_pos", 1'b1, 1'b0, 8'd0, 400, 400, -100, 511, 1'b0, 1'b0);
    run_layer("clip_neg", 1'b1, 1'b0, 8'd0, -500, -500, 0, -512, 1'b0, 1'b0);
    run_layer("noclip_wrap", 1'b0, 1'b0, 8'd0, 400, 400, -100, -324, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    run_layer("relu_neg100", 1'b0, 1'b1, 8'd64, -100, 0, 0, -25, 1'b0, 1'b0);
    run_layer("relu_neg3", 1'b0, 1'b1, 8'd64, -3, 0, 0, -1, 1'b0, 1'b0);
    run_layer("relu_pos77", 1'b0, 1'b1, 8'd64, 70, 10, -3, 77, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int ubase, fbase, obase;
    ubase = unstable; fbase = fstall_cnt; obase = ostall_cnt;
    fstall_target = fstall_cnt + 5;
    ostall_target = ostall_cnt + 10;
    run_layer("backpressure", 1'b0, 1'b0, 8'd0, 100, 100, 100, 300, 1'b0, 1'b0);
    n_checks++;
    if (fstall_cnt - fbase != 5 || ostall_cnt - obase != 10) begin
      n_fail++; $display("FAIL bp_stalls_applied: got %0d/%0d expected 5/10", fstall_cnt - fbase, ostall_cnt - obase);
    end
    n_checks++;
    if (unstable != ubase) begin n_fail++; $display("FAIL bp_stability: got %0d changes expected 0", unstable - ubase); end
  endtask

  task automatic test_protocol();
    inj_target = inj_cnt + 1;
    run_layer("protocol", 1'b0, 1'b0, 8'd0, 100, 100, 100, 300, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL protocol_err_sticky: got %b expected 1", err); end
    run_layer("err_clear", 1'b0, 1'b0, 8'd0, 100, 100, 100, 300, 1'b0, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_start: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    int base, dbase;
    base = pixq.size();
    dbase = done_cnt;
    @(negedge clk);
    part[0] = 100; part[1] = 100; part[2] = 100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && pixq.size() - base < 3; i++) @(negedge clk);
    for (int i = 0; i < 50 && !(busy && !fetch_valid && !out_valid); i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, out_valid, fetch_valid, done} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 0000", {busy, out_valid, fetch_valid, done});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt != dbase || pixq.size() - base != 3) begin
      n_fail++; $display("FAIL midreset_no_done: got done %0d pixels %0d expected 0 and 3", done_cnt - dbase, pixq.size() - base);
    end
    run_layer("after_reset", 1'b0, 1'b0, 8'd0, 100, 100, 100, 300, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_relu();
    test_backpressure();
    test_protocol();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
